async_fifo_wr_framer: RTL and testbench

Write-side packet framer that feeds the write port of the team's dual-clock FIFO from a valid/ready stream. It lives entirely in the write clock domain. It buffers incoming beats in a 2-entry skid queue and drives the FIFO write strobe and data while respecting the FIFO full flag. After the last data word of each packet it appends one trailer word carrying the packet length, so the read-side consumer can delimit packets.

---
 rtl/async_fifo_wr_framer.sv | 145 ++++++++++++++
 tb/tb_async_fifo_wr_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_framer.sv
// Write-domain packet framer: 2-entry skid queue feeding a dual-clock FIFO write port,
// appending a saturating length trailer after the last data word of each packet.
module async_fifo_wr_framer #(
    parameter int unsigned G_WIDTH     = 8,
    parameter int unsigned G_CNT_WIDTH = 16
) (
    input  logic                   i_clk_w,
    input  logic                   i_arstN_w,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [G_WIDTH-1:0]     i_data,
    input  logic                   i_last,
    input  logic                   i_full,
    output logic                   o_wren_w,
    output logic [G_WIDTH-1:0]     o_data_w,
    output logic                   o_pkt_done,
    output logic [G_CNT_WIDTH-1:0] o_pkt_count,
    output logic                   o_busy
);

    localparam int unsigned OCC_W = 2;
    localparam logic [G_WIDTH-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_TRAILER = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_nxt;
    logic [G_WIDTH-1:0] q_data0;
    logic [G_WIDTH-1:0] q_data1;
    logic               q_last0;
    logic               q_last1;
    logic [G_WIDTH-1:0] len;
    logic               push;
    logic               wr_done;
    logic               pop;
    logic               trl_done;

    // Outputs decoded purely from registers; no path from i_full/i_valid to o_ready.
    assign o_ready  = (occ != OCC_W'(2));
    assign o_wren_w = (state != S_IDLE);
    assign o_data_w = (state == S_TRAILER) ? len :
                      (state == S_DATA)    ? q_data0 : '0;
    assign o_busy   = (occ != '0) || (state == S_TRAILER);

    assign push     = i_valid && o_ready;
    assign wr_done  = o_wren_w && !i_full;
    assign pop      = (state == S_DATA) && wr_done;
    assign trl_done = (state == S_TRAILER) && wr_done;
    assign occ_nxt  = occ + OCC_W'(push) - OCC_W'(pop);

    always_ff @(posedge i_clk_w or negedge i_arstN_w) begin
        if (!i_arstN_w) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (push) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (pop) begin
                    if (q_last0) begin
                        state_nxt = S_TRAILER;
                    end else if (occ_nxt != '0) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_TRAILER: begin
                if (wr_done) begin
                    state_nxt = (occ_nxt != '0) ? S_DATA : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Skid queue: entry 0 is the head; a simultaneous push/pop at occupancy 1 refills the head.
    always_ff @(posedge i_clk_w or negedge i_arstN_w) begin
        if (!i_arstN_w) begin
            occ     <= '0;
            q_data0 <= '0;
            q_data1 <= '0;
            q_last0 <= 1'b0;
            q_last1 <= 1'b0;
        end else begin
            occ <= occ_nxt;
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) begin
                        q_data0 <= i_data;
                        q_last0 <= i_last;
                    end else begin
                        q_data1 <= i_data;
                        q_last1 <= i_last;
                    end
                end
                2'b01: begin
                    q_data0 <= q_data1;
                    q_last0 <= q_last1;
                end
                2'b11: begin
                    q_data0 <= i_data;
                    q_last0 <= i_last;
                end
                default: ;
            endcase
        end
    end

    // Saturating per-packet length and completed-packet accounting.
    always_ff @(posedge i_clk_w or negedge i_arstN_w) begin
        if (!i_arstN_w) begin
            len         <= '0;
            o_pkt_done  <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            o_pkt_done <= trl_done;
            if (pop && (len != LEN_MAX)) begin
                len <= len + G_WIDTH'(1);
            end else if (trl_done) begin
                len <= '0;
            end
            if (trl_done) begin
                o_pkt_count <= o_pkt_count + G_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_framer.sv
// Scoreboard bench for async_fifo_wr_framer: directed packets push expected FIFO words,
// a negedge monitor pops and compares every completed write and trailer pulse.
module tb_async_fifo_wr_framer;

    logic        i_clk_w   = 1'b0;
    logic        i_arstN_w = 1'b0;
    logic        i_valid   = 1'b0;
    logic        o_ready;
    logic [7:0]  i_data    = 8'h00;
    logic        i_last    = 1'b0;
    logic        i_full    = 1'b0;
    logic        o_wren_w;
    logic [7:0]  o_data_w;
    logic        o_pkt_done;
    logic [15:0] o_pkt_count;
    logic        o_busy;

    typedef struct {
        logic [7:0] d;
        logic       trl;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_chk    = 0;
    int   n_wr     = 0;
    int   n_done   = 0;
    int   exp_pkts = 0;
    logic done_exp = 1'b0;

    async_fifo_wr_framer #(.G_WIDTH(8), .G_CNT_WIDTH(16)) dut (
        .i_clk_w    (i_clk_w),
        .i_arstN_w  (i_arstN_w),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_last     (i_last),
        .i_full     (i_full),
        .o_wren_w   (o_wren_w),
        .o_data_w   (o_data_w),
        .o_pkt_done (o_pkt_done),
        .o_pkt_count(o_pkt_count),
        .o_busy     (o_busy)
    );

    always #5 i_clk_w = ~i_clk_w;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic trl);
        exp_t e;
        e.d   = d;
        e.trl = trl;
        return e;
    endfunction

    // Monitor: a write completes at the next posedge when wren && !full are seen here.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk_w);
            if (i_arstN_w) begin
                if (o_pkt_done) n_done++;
                if (o_pkt_done || done_exp) begin
                    check("pkt_done", 32'(o_pkt_done), 32'(done_exp));
                    if (done_exp) check("pkt_count_on_done", 32'(o_pkt_count), 32'(exp_pkts));
                end
                done_exp = 1'b0;
                if (o_wren_w && !i_full) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_write: got 0x%0h expected none", o_data_w);
                    end else begin
                        e = exp_q.pop_front();
                        check("fifo_word", 32'(o_data_w), 32'(e.d));
                        if (e.trl) begin
                            done_exp = 1'b1;
                            exp_pkts++;
                        end
                    end
                end
            end else begin
                done_exp = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int   n;
        logic ok;
        n       = 0;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        while (!ok) begin
            @(negedge i_clk_w);
            ok = o_ready;
            @(posedge i_clk_w);
            #1;
            n++;
            if (!ok && n > 1000) begin
                n_chk++;
                $display("FAIL send_timeout: got ready=0 expected ready=1");
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
            @(posedge i_clk_w);
            #1;
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(posedge i_clk_w);
        #1;
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks outputs immediately.
    task automatic do_reset();
        #2;
        i_arstN_w = 1'b0;
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_wren", 32'(o_wren_w), 32'd0);
        check("rst_data", 32'(o_data_w), 32'd0);
        check("rst_pkt_done", 32'(o_pkt_done), 32'd0);
        check("rst_pkt_count", 32'(o_pkt_count), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        exp_pkts = 0;
        @(posedge i_clk_w);
        #3;
        i_arstN_w = 1'b1;
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_wren", 32'(o_wren_w), 32'd0);
        @(posedge i_clk_w);
        #1;
    endtask

    initial begin
        int wr0;
        int dn0;

        // Initial reset
        #1;
        check("init_ready", 32'(o_ready), 32'd1);
        check("init_wren", 32'(o_wren_w), 32'd0);
        check("init_pkt_count", 32'(o_pkt_count), 32'd0);
        check("init_busy", 32'(o_busy), 32'd0);
        repeat (3) @(posedge i_clk_w);
        #3;
        i_arstN_w = 1'b1;
        @(posedge i_clk_w);
        #1;

        // 3-beat packet, no backpressure: 4 writes on consecutive edges
        exp_q.push_back(mk(8'h11, 1'b0));
        exp_q.push_back(mk(8'h22, 1'b0));
        exp_q.push_back(mk(8'h33, 1'b0));
        exp_q.push_back(mk(8'h03, 1'b1));
        wr0 = n_wr;
        dn0 = n_done;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        repeat (2) @(posedge i_clk_w);
        #1;
        check("consecutive_writes", 32'(n_wr - wr0), 32'd4);
        wait_drain();
        check("t1_pkt_count", 32'(o_pkt_count), 32'd1);
        check("t1_done_pulses", 32'(n_done - dn0), 32'd1);
        do_reset();

        // Same packet with FIFO full for 5 cycles after the first write
        exp_q.push_back(mk(8'h11, 1'b0));
        exp_q.push_back(mk(8'h22, 1'b0));
        exp_q.push_back(mk(8'h33, 1'b0));
        exp_q.push_back(mk(8'h03, 1'b1));
        dn0 = n_done;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        i_full = 1'b1;
        fork
            send(8'h33, 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge i_clk_w);
                    check("full_hold_wren", 32'(o_wren_w), 32'd1);
                    check("full_hold_data", 32'(o_data_w), 32'h22);
                    if (k >= 1) check("full_ready_low", 32'(o_ready), 32'd0);
                end
            end
        join
        @(posedge i_clk_w);
        #1;
        i_full = 1'b0;
        wait_drain();
        check("t2_pkt_count", 32'(o_pkt_count), 32'd1);
        check("t2_done_pulses", 32'(n_done - dn0), 32'd1);
        do_reset();

        // Back-to-back single-beat packets
        exp_q.push_back(mk(8'hA0, 1'b0));
        exp_q.push_back(mk(8'h01, 1'b1));
        exp_q.push_back(mk(8'hB0, 1'b0));
        exp_q.push_back(mk(8'h01, 1'b1));
        dn0 = n_done;
        send(8'hA0, 1'b1);
        send(8'hB0, 1'b1);
        wait_drain();
        check("t3_pkt_count", 32'(o_pkt_count), 32'd2);
        check("t3_done_pulses", 32'(n_done - dn0), 32'd2);
        do_reset();

        // 300-beat packet: length saturates at 0xFF
        for (int i = 0; i < 300; i++) exp_q.push_back(mk(8'(i), 1'b0));
        exp_q.push_back(mk(8'hFF, 1'b1));
        wr0 = n_wr;
        for (int i = 0; i < 300; i++) send(8'(i), (i == 299));
        wait_drain();
        check("t4_write_count", 32'(n_wr - wr0), 32'd301);
        check("t4_pkt_count", 32'(o_pkt_count), 32'd1);
        do_reset();

        // Reset after 2 of 4 beats: partial packet discarded
        exp_q.push_back(mk(8'h01, 1'b0));
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        check("t5_busy_before_rst", 32'(o_wren_w), 32'd1);
        do_reset();
        wr0 = n_wr;
        repeat (5) @(posedge i_clk_w);
        #1;
        check("t5_no_writes", 32'(n_wr - wr0), 32'd0);
        exp_q.push_back(mk(8'h5A, 1'b0));
        exp_q.push_back(mk(8'h01, 1'b1));
        send(8'h5A, 1'b1);
        wait_drain();
        check("t5_pkt_count", 32'(o_pkt_count), 32'd1);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
